// File: rtl/conv_enc_pkg.sv
// Shared FSM type, default code parameters and legal parameter ranges
// for the convolutional encoder.
package conv_enc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    TAIL = 2'd2
  } enc_state_t;

  localparam int DEF_K = 3;
  localparam int DEF_N = 2;
  localparam logic [DEF_N*DEF_K-1:0] DEF_G = {3'b111, 3'b011};

  localparam int K_MIN = 2;
  localparam int K_MAX = 9;
  localparam int N_MIN = 2;
  localparam int N_MAX = 4;

endpackage

// File: rtl/conv_enc_serializer.sv
// Parallel-load N-bit shift register that emits bit 0 first, one bit per out_ready.
// A load in the final bit's transfer cycle replaces the symbol with no bubble.
module conv_enc_serializer #(
  parameter int N = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 load,
  input  logic [N-1:0]         load_sym,
  input  logic                 load_last,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic                 out_bit,
  output logic                 out_last,
  output logic [$clog2(N)-1:0] bit_idx,
  output logic                 sym_last,
  output logic                 sym_done
);
  localparam int IW = $clog2(N);

  logic [N-1:0]  sreg;
  logic          valid;
  logic [IW-1:0] idx;
  logic          last;
  logic          at_end;

  assign at_end    = (idx == IW'(N - 1));
  assign out_valid = valid;
  assign out_bit   = sreg[0];
  assign out_last  = valid && last && at_end;
  assign bit_idx   = idx;
  assign sym_last  = last;
  assign sym_done  = valid && out_ready && at_end;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sreg  <= '0;
      valid <= 1'b0;
      idx   <= '0;
      last  <= 1'b0;
    end else if (load) begin
      sreg  <= load_sym;
      valid <= 1'b1;
      idx   <= '0;
      last  <= load_last;
    end else if (valid && out_ready) begin
      sreg <= sreg >> 1;
      if (at_end) begin
        valid <= 1'b0;
        idx   <= '0;
        last  <= 1'b0;
      end else begin
        idx <= idx + IW'(1);
      end
    end
  end

endmodule

// File: rtl/conv_encoder.sv
// Rate-1/N convolutional encoder: first code bit one cycle after accept, then one bit/cycle;
// input held off while out_ready is low. CONV_ENC_TAIL_EN appends K-1 zero flush symbols per frame.
module conv_encoder
  import conv_enc_pkg::*;
#(
  parameter int             K = DEF_K,
  parameter int             N = DEF_N,
  parameter logic [N*K-1:0] G = DEF_G
) (
  input  logic clock,
  input  logic reset,
  input  logic in_valid,
  output logic in_ready,
  input  logic in_bit,
  input  logic in_last,
  output logic out_valid,
  input  logic out_ready,
  output logic out_bit,
  output logic out_last
);
  localparam int IW = $clog2(N);
  localparam int TW = 4;

  if (K < K_MIN || K > K_MAX || N < N_MIN || N > N_MAX) begin : g_param_check
    $error("conv_encoder: K or N out of range");
  end

  enc_state_t    fsm, fsm_nx;
  logic [K-2:0]  state, state_nx;
  logic          tail_pending, tail_pending_nx;
  logic [TW-1:0] tail_cnt, tail_cnt_nx;

  logic          load, load_last;
  logic [N-1:0]  load_sym;
  logic [IW-1:0] bit_idx;
  logic          sym_last, sym_done;
  logic          in_fire, frame_end;
  logic [K-2:0]  base_state;
  logic [K-1:0]  data_win;

  function automatic logic [N-1:0] encode(input logic [K-1:0] win);
    logic [N-1:0] c;
    for (int i = 0; i < N; i++) c[i] = ^(G[i*K +: K] & win);
    return c;
  endfunction

  // Accept a new bit only when the serializer is empty or its last bit leaves this cycle.
  assign in_ready = !reset && ((fsm == IDLE) ||
                    (fsm == DATA && bit_idx == IW'(N - 1) && out_ready && !tail_pending));
  assign in_fire    = in_valid && in_ready;
  assign frame_end  = sym_done && sym_last;
  // A frame ending this cycle must not leak its history into a bit accepted alongside it.
  assign base_state = frame_end ? '0 : state;
  assign data_win   = {base_state, in_bit};

`ifdef CONV_ENC_TAIL_EN
  logic [K-1:0] tail_win;
  assign tail_win = {state, 1'b0};
`endif

  always_comb begin
    fsm_nx          = fsm;
    state_nx        = state;
    tail_pending_nx = tail_pending;
    tail_cnt_nx     = tail_cnt;
    load            = 1'b0;
    load_sym        = '0;
    load_last       = 1'b0;
    if (in_fire) begin
      load     = 1'b1;
      load_sym = encode(data_win);
      state_nx = data_win[K-2:0];
      fsm_nx   = DATA;
`ifdef CONV_ENC_TAIL_EN
      tail_pending_nx = in_last;
`else
      load_last = in_last;
`endif
    end else if (sym_done) begin
      fsm_nx   = IDLE;
      state_nx = base_state;
`ifdef CONV_ENC_TAIL_EN
      if (tail_pending || (fsm == TAIL && tail_cnt != '0)) begin
        load            = 1'b1;
        load_sym        = encode(tail_win);
        state_nx        = tail_win[K-2:0];
        fsm_nx          = TAIL;
        tail_pending_nx = 1'b0;
        tail_cnt_nx     = tail_pending ? TW'(K - 2) : tail_cnt - TW'(1);
        load_last       = tail_pending ? (K == 2) : (tail_cnt == TW'(1));
      end
`endif
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fsm          <= IDLE;
      state        <= '0;
      tail_pending <= 1'b0;
      tail_cnt     <= '0;
    end else begin
      fsm          <= fsm_nx;
      state        <= state_nx;
      tail_pending <= tail_pending_nx;
      tail_cnt     <= tail_cnt_nx;
    end
  end

  conv_enc_serializer #(
    .N(N)
  ) u_ser (
    .clock     (clock),
    .reset     (reset),
    .load      (load),
    .load_sym  (load_sym),
    .load_last (load_last),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_bit   (out_bit),
    .out_last  (out_last),
    .bit_idx   (bit_idx),
    .sym_last  (sym_last),
    .sym_done  (sym_done)
  );

endmodule

// File: doc/conv_encoder.md
CONV_ENCODER -- requirements
Module: conv_encoder

Interface
REQ-001 Parameter K, 3, constraint length; 2 to 9 inclusive; state register width K-1.
REQ-002 Parameter N, 2, code bits per input bit (rate 1/N); 2 to 4 inclusive.
REQ-003 Parameter G, {3'b111,3'b011}, N*K-bit packed generator taps; slice i = G[i*K +: K]; tap bit 0 = current input, tap bit j = input j bits earlier.
REQ-004 clock  input  1  clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 in_valid  input  1  in_bit/in_last valid.
REQ-007 in_ready  output  1  encoder accepts an input bit this cycle.
REQ-008 in_bit  input  1  data bit to encode.
REQ-009 in_last  input  1  marks final data bit of a frame.
REQ-010 out_valid  output  1  out_bit valid.
REQ-011 out_ready  input  1  downstream accepts out_bit this cycle.
REQ-012 out_bit  output  1  serial code bit.
REQ-013 out_last  output  1  marks final code bit of a frame.

Function
REQ-014 Input transfer occurs when in_valid and in_ready are both high; output transfer occurs when out_valid and out_ready are both high.
REQ-015 On input transfer, the symbol c[i] = XOR-reduce(G slice i AND {state, in_bit}) for i = 0..N-1 is loaded into the serializer, and state shifts in in_bit (state[0] = newest bit).
REQ-016 Serial order: c[0] first, c[N-1] last; exactly one code bit per output transfer.
REQ-017 FSM states: IDLE (serializer empty), DATA (emitting data symbol), TAIL (emitting flush symbols).
REQ-018 in_ready is high in IDLE, and in DATA while bit index = N-1 with out_ready high and no tail pending; in_ready is low otherwise.
REQ-019 Throughput: with in_valid and out_ready held high, one code bit per cycle, no bubbles between symbols.
REQ-020 First out_valid occurs one cycle after the first input transfer from IDLE.
REQ-021 While out_valid is high and out_ready is low, out_bit, out_last and the bit index hold stable.
REQ-022 out_valid is never withdrawn before its transfer.
REQ-023 Input transfer and final-bit output transfer in the same cycle: the new symbol is loaded and emitted next cycle; state advances exactly once.
REQ-024 After the last code bit of a frame transfers, state equals zero and the FSM returns to IDLE unless a new input is accepted in the same cycle.

Reset
REQ-025 While reset is high: FSM = IDLE, state = 0, bit index = 0, tail count = 0, out_valid = 0, out_bit = 0, out_last = 0, in_ready = 0.
REQ-026 Reset mid-frame abandons the frame with no further output; the first cycle after reset deassertion has in_ready = 1.

Configuration
REQ-027 Macro CONV_ENC_TAIL_EN defined: after the in_last symbol, the FSM enters TAIL and encodes K-1 zero bits; in_ready stays low throughout TAIL; out_last is set on bit N-1 of the last tail symbol only.
REQ-028 Macro CONV_ENC_TAIL_EN undefined: no tail; out_last is set on bit N-1 of the in_last symbol; state is cleared to zero when that bit transfers.

Structure
REQ-029 Package conv_enc_pkg holds the FSM state enum typedef, the default K/N/G constants, and the K and N range limits.
REQ-030 Sub-module conv_enc_serializer: N-bit parallel-load shift register with valid/ready, bit index, and last flag; conv_encoder instantiates it once.

Verification
REQ-031 Defaults, tail on; inputs 1,0,1,1 (last on 4th), out_ready = 1 -> 12 bits 1,1,1,1,1,0,0,0,1,0,0,1; out_last on 12th only; no bubbles.
REQ-032 Same stimulus, tail off -> 8 bits 1,1,1,1,1,0,0,0; out_last on 8th; next frame single input 1 -> 1,1 (state cleared).
REQ-033 Defaults, out_ready toggled 1,0,0,1 repeatedly -> out_bit/out_last stable while stalled; output sequence identical to REQ-031.
REQ-034 Reset asserted during 3rd symbol of REQ-031 -> out_valid = 0 same cycle; after release, in_ready = 1; a fresh frame matches REQ-031.
REQ-035 K=4, N=3, G = {4'b1011,4'b1101,4'b1111}, tail on; input single bit 1 with last -> 12 bits 1,1,1,1,0,1,1,1,0,1,1,1.
REQ-036 Back-to-back frames with continuous in_valid -> in_ready low during TAIL; second frame starts from zero state; output matches the golden model.
